// File: rtl/hack_pkg.sv
// hack_pkg: shared address width, jump-field bit positions and PC-unit state encoding.
package hack_pkg;
  localparam int ADDR_W = 15;
  localparam int JGT = 0;
  localparam int JEQ = 1;
  localparam int JLT = 2;
  typedef enum logic {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_e;
endpackage

// File: rtl/hack_jump_cond.sv
// hack_jump_cond: evaluates the C-instruction jump field against the ALU flags.
module hack_jump_cond
  import hack_pkg::*;
(
  input  logic       is_c_instr,
  input  logic [2:0] jump_bits,
  input  logic       zr,
  input  logic       ng,
  output logic       take
);
  always_comb
    take = is_c_instr & ((jump_bits[JLT] & ng) | (jump_bits[JEQ] & zr) | (jump_bits[JGT] & ~ng & ~zr));
endmodule

// File: rtl/hack_pc_unit.sv
// hack_pc_unit: HACK program counter with jump selection and terminal-loop halt detection.
module hack_pc_unit #(
  parameter int ADDR_W      = hack_pkg::ADDR_W,
  parameter bit HALT_DETECT = 1'b1,
  parameter int HALT_REPEAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              is_c_instr,
  input  logic [2:0]        jump_bits,
  input  logic              zr,
  input  logic              ng,
  input  logic [ADDR_W-1:0] a_reg,
  output logic [ADDR_W-1:0] pc,
  output logic              jump_taken,
  output logic              halted
);
  import hack_pkg::*;
  localparam int CW = $clog2(HALT_REPEAT + 1);
  logic take, loop, halting;
  state_e state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic jt_q, jt_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  hack_jump_cond u_cond (
    .is_c_instr(is_c_instr),
    .jump_bits (jump_bits),
    .zr        (zr),
    .ng        (ng),
    .take      (take)
  );
  // A loop jump targets the current instruction or the "@END" just before it.
  always_comb begin
    loop = take & (a_reg == pc_q | a_reg == pc_q - 1'b1);
    cnt_inc = (cnt_q == CW'(HALT_REPEAT)) ? cnt_q : cnt_q + 1'b1;
    halting = HALT_DETECT && loop && cnt_inc == CW'(HALT_REPEAT);
    state_d = state_q;
    pc_d = pc_q;
    jt_d = jt_q;
    cnt_d = cnt_q;
    if (state_q == ST_HALTED) jt_d = 1'b0;
    else if (en) begin
      pc_d = take ? a_reg : pc_q + 1'b1;
      jt_d = take;
      cnt_d = loop ? cnt_inc : take ? '0 : cnt_q;
      state_d = halting ? ST_HALTED : ST_RUN;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q <= '0;
      jt_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      jt_q <= jt_d;
      cnt_q <= cnt_d;
    end
  end
  always_comb begin
    pc = pc_q;
    jump_taken = jt_q;
    halted = state_q == ST_HALTED;
  end
endmodule

// File: tb/tb_hack_pc_unit.sv
// tb_hack_pc_unit: scoreboard bench; a behavioural model predicts pc/jump_taken/halted per edge.
module tb_hack_pc_unit;
  localparam int AW = 15;
  localparam int MASK = 32'h7FFF;
  localparam int REP = 2;
  logic clk = 1'b0;
  logic reset = 1'b1, en = 1'b0, is_c_instr = 1'b0, zr = 1'b0, ng = 1'b0;
  logic [2:0] jump_bits = 3'b000;
  logic [AW-1:0] a_reg = '0;
  logic [AW-1:0] pc;
  logic jump_taken, halted;
  typedef struct {int pc; bit jt; bit h; string tag;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  int m_pc = 0, m_cnt = 0;
  bit m_jt = 0, m_h = 0;
  hack_pc_unit #(.ADDR_W(AW), .HALT_DETECT(1'b1), .HALT_REPEAT(REP)) dut (
    .clk(clk), .reset(reset), .en(en), .is_c_instr(is_c_instr), .jump_bits(jump_bits),
    .zr(zr), .ng(ng), .a_reg(a_reg), .pc(pc), .jump_taken(jump_taken), .halted(halted)
  );
  always #5 clk = ~clk;
  // Reference model: the program-counter rules applied to plain integers.
  task automatic step(input bit r, input bit e, input bit c, input int jb, input bit z, input bit n,
                      input int a, input string tag);
    bit take, lp;
    @(negedge clk);
    #1;
    reset = r; en = e; is_c_instr = c; jump_bits = 3'(jb); zr = z; ng = n; a_reg = AW'(a);
    take = c && ((jb[2] && n) || (jb[1] && z) || (jb[0] && !n && !z));
    lp = take && (a == m_pc || a == ((m_pc - 1) & MASK));
    if (r) begin
      m_pc = 0; m_jt = 0; m_h = 0; m_cnt = 0;
    end else if (m_h) m_jt = 0;
    else if (e) begin
      if (take) begin
        m_cnt = lp ? ((m_cnt + 1 > REP) ? REP : m_cnt + 1) : 0;
        if (lp && m_cnt == REP) m_h = 1;
        m_pc = a & MASK;
      end else m_pc = (m_pc + 1) & MASK;
      m_jt = take;
    end
    q.push_back('{m_pc, m_jt, m_h, tag});
  endtask
  task automatic adv(input int k, input string tag);
    for (int i = 0; i < k; i++) step(0, 1, 0, 0, 0, 0, 0, tag);
  endtask
  task automatic jmp(input int a, input string tag);
    step(0, 1, 1, 7, 0, 0, a, tag);
  endtask
  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x = q.pop_front();
        checks++;
        if (pc !== AW'(x.pc) || jump_taken !== x.jt || halted !== x.h) begin
          errors++;
          $display("FAIL %s: got pc=%h jt=%b halted=%b, expected pc=%h jt=%b halted=%b",
                   x.tag, pc, jump_taken, halted, AW'(x.pc), x.jt, x.h);
        end
      end
    end
  end
  initial begin : driver
    int a;
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, 0, "reset");
    adv(10, "count");
    step(0, 1, 1, 3'b010, 1, 0, 16'h0100, "jeq_taken");
    jmp(10, "back_to_10");
    step(0, 1, 1, 3'b010, 0, 0, 16'h0100, "jeq_not_taken");
    for (int jb = 0; jb < 8; jb++)
      for (int f = 0; f < 3; f++)
        step(0, 1, 1, jb, f == 1, f == 2, 16'h1000 + (jb * 3 + f) * 64, "sweep");
    step(0, 1, 0, 7, 1, 1, 16'h2000, "a_instr_no_jump");
    jmp(16'h7FFF, "to_top");
    for (int i = 0; i < 4; i++) step(0, 0, 1, 7, 0, 0, i * 5, "stall");
    adv(1, "wrap");
    step(0, 0, 0, 0, 0, 0, 0, "stall_after_wrap");
    jmp(20, "to_20");
    adv(1, "at_end_label");
    jmp(20, "loop1");
    adv(1, "at_end_label2");
    jmp(20, "loop2_halt");
    for (int i = 0; i < 6; i++) step(0, i % 2, 1, 7, 0, 0, i * 77, "halted_frozen");
    step(1, 0, 0, 0, 0, 0, 0, "reset_from_halt");
    jmp(20, "to_20_again");
    adv(1, "label_again");
    jmp(20, "loop_once");
    adv(1, "after_loop_once");
    jmp(16'h0030, "to_30");
    jmp(16'h0030, "self_loop");
    jmp(16'h0040, "break_loop");
    jmp(16'h0040, "loop_after_break");
    jmp(16'h0040, "loop_halt2");
    step(1, 1, 0, 0, 0, 0, 0, "reset2");
    for (int i = 0; i < 300; i++) begin
      a = $urandom_range(0, 3) == 0 ? ((m_pc - int'($urandom_range(0, 1))) & MASK) : int'($urandom_range(0, MASK));
      step($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 7)), $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, a, "random");
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
